// File: rtl/calc_pkg.sv
// calc_pkg: shared types for the calculator datapath and keypad sequencer.
// Holds the BCD number format, button/op encodings, the sequencer state
// enum and small decode helpers. Used by calc_entry and calc_sequencer.
package calc_pkg;

  localparam int NumDigits = 8;
  localparam int ExpW      = 4;

  typedef logic [3:0] bcd_t;

  // Digit buttons map onto 0..9 so the low nibble is the BCD digit.
  typedef enum logic [4:0] {
    B_0 = 5'd0, B_1 = 5'd1, B_2 = 5'd2, B_3 = 5'd3, B_4 = 5'd4,
    B_5 = 5'd5, B_6 = 5'd6, B_7 = 5'd7, B_8 = 5'd8, B_9 = 5'd9,
    B_DOT        = 5'd10,
    B_ON         = 5'd11,
    B_OFF        = 5'd12,
    B_OP_ADD     = 5'd13,
    B_OP_SUB     = 5'd14,
    B_OP_MUL     = 5'd15,
    B_OP_DIV     = 5'd16,
    B_OP_EQ      = 5'd17,
    B_OP_PERCENT = 5'd18,
    B_OP_SQRT    = 5'd19,
    B_MEM_ADD    = 5'd20,
    B_MEM_SUB    = 5'd21,
    B_MEM_RC     = 5'd22,
    B_NONE       = 5'd23,
    B_UNKNOWN    = 5'd31
  } active_button_t;

  typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_MUL, OP_DIV} op_t;

  // value = significand x 10^-exponent, significand[0] is the LSD.
  typedef struct packed {
    logic                       error;
    logic                       sign;
    logic [ExpW-1:0]            exponent;
    bcd_t [NumDigits-1:0]       significand;
  } num_t;

  localparam num_t NUM_ZERO = '0;

  typedef enum logic [2:0] {
    S_OFF, S_ENTRY_A, S_OP_PEND, S_ENTRY_B, S_ALU_WAIT, S_RESULT, S_ERROR
  } seq_state_t;

  function automatic logic isMemButton(active_button_t b);
    return b inside {B_MEM_ADD, B_MEM_SUB, B_MEM_RC};
  endfunction

  function automatic logic isDigit(active_button_t b);
    return b <= B_9;
  endfunction

  function automatic logic isOpButton(active_button_t b);
    return b inside {B_OP_ADD, B_OP_SUB, B_OP_MUL, B_OP_DIV};
  endfunction

  // Subtraction is an add of the negated operand.
  function automatic op_t button2op(active_button_t b);
    case (b)
      B_OP_MUL: return OP_MUL;
      B_OP_DIV: return OP_DIV;
      default:  return OP_ADD;
    endcase
  endfunction

  function automatic num_t neg(num_t x);
    num_t r = x;
    r.sign = ~x.sign;
    return r;
  endfunction

endpackage

// File: rtl/calc_entry.sv
// calc_entry: digit/dot accumulator for one operand being typed in.
// Ports: clk/rst_n; clear (start from zero, may coincide with a key);
// digit_valid + digit (BCD); dot_valid; load + load_value (replace the
// entry wholesale); value (current entry as num_t).
module calc_entry
  import calc_pkg::*;
#(
  parameter int NumDigits = calc_pkg::NumDigits
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic digit_valid,
  input  bcd_t digit,
  input  logic dot_valid,
  input  logic load,
  input  num_t load_value,
  output num_t value
);

  localparam int CntW = $clog2(NumDigits + 1);

  num_t            val_q, base_val, nxt_val;
  logic [CntW-1:0] cnt_q, base_cnt, nxt_cnt;
  logic            dot_q, base_dot, nxt_dot;

  always_comb begin
    base_val = clear ? NUM_ZERO : val_q;
    base_cnt = clear ? '0 : cnt_q;
    base_dot = clear ? 1'b0 : dot_q;
    nxt_val  = base_val;
    nxt_cnt  = base_cnt;
    nxt_dot  = base_dot;
    if (load) begin
      // A recalled value is complete: lock it against further digits.
      nxt_val = load_value;
      nxt_cnt = CntW'(NumDigits);
      nxt_dot = 1'b1;
    end else if (dot_valid) begin
      nxt_dot = 1'b1;
    end else if (digit_valid) begin
      // Leading zeros before any dot do not consume digit positions.
      if (!(base_val.significand == '0 && !base_dot && digit == '0) &&
          base_cnt < CntW'(NumDigits)) begin
        nxt_val.significand = {base_val.significand[calc_pkg::NumDigits-2:0], digit};
        nxt_cnt = base_cnt + CntW'(1);
        if (base_dot) nxt_val.exponent = base_val.exponent + ExpW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= NUM_ZERO;
      cnt_q <= '0;
      dot_q <= 1'b0;
    end else begin
      val_q <= nxt_val;
      cnt_q <= nxt_cnt;
      dot_q <= nxt_dot;
    end
  end

  assign value = val_q;

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad controller. Builds operands from button events,
// sequences the shared ALU over req/ack, owns the display value.
// Ports: clk_i, rst_ni (async low); btn_valid_i/btn_i button events;
// busy_o; alu_req_o/alu_op_o/alu_a_o/alu_b_o request, alu_ack_i/alu_result_i
// response; display_o/display_en_o; mem_flag_o.
// Build option: define CALC_MEMORY_EN to add the M+/M-/MRC memory register.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int NumDigits = calc_pkg::NumDigits
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     btn_valid_i,
  input  logic [4:0]               btn_i,
  output logic                     busy_o,
  output logic                     alu_req_o,
  output logic [1:0]               alu_op_o,
  output logic [$bits(num_t)-1:0]  alu_a_o,
  output logic [$bits(num_t)-1:0]  alu_b_o,
  input  logic                     alu_ack_i,
  input  logic [$bits(num_t)-1:0]  alu_result_i,
  output logic [$bits(num_t)-1:0]  display_o,
  output logic                     display_en_o,
  output logic                     mem_flag_o
);

  seq_state_t     state_q, ret_q, iss_ret;
  num_t           a_q, disp_q, alu_a_q, alu_b_q, ent_val, ent_load_val, result, disp_val;
  num_t           iss_a, iss_b;
  op_t            pend_op_q, alu_op_q, iss_op;
  logic           sub_q, busy_q, alu_req_q, disp_en_q;
  active_button_t btn;
  logic           take, is_digit, is_dot, is_op, is_key, in_entry, mem_rc, mem_addsub;
  logic           ent_clear, ent_digit, ent_dot, ent_load;
  logic           issue, iss_sub, iss_mem;

  assign btn      = active_button_t'(btn_i);
  assign result   = num_t'(alu_result_i);
  assign take     = btn_valid_i && !busy_q;
  assign is_digit = isDigit(btn);
  assign is_dot   = (btn == B_DOT);
  assign is_op    = isOpButton(btn);
  assign is_key   = is_digit || is_dot;
  assign in_entry = (state_q == S_ENTRY_A) || (state_q == S_ENTRY_B);

`ifdef CALC_MEMORY_EN
  num_t mem_q;
  logic mem_op_q;
  assign mem_rc       = (btn == B_MEM_RC);
  assign mem_addsub   = isMemButton(btn) && !mem_rc;
  assign ent_load_val = mem_q;
  assign mem_flag_o   = (mem_q.significand != '0);
`else
  assign mem_rc       = 1'b0;
  assign mem_addsub   = 1'b0;
  assign ent_load_val = NUM_ZERO;
  assign mem_flag_o   = 1'b0;
`endif

  // Entry register control. From OP_PEND/RESULT a key starts a fresh entry.
  always_comb begin
    ent_clear = 1'b0;
    ent_digit = 1'b0;
    ent_dot   = 1'b0;
    ent_load  = 1'b0;
    if (take) begin
      case (state_q)
        S_ENTRY_A, S_ENTRY_B: begin
          ent_digit = is_digit;
          ent_dot   = is_dot;
          ent_load  = mem_rc;
        end
        S_OP_PEND, S_RESULT: begin
          ent_clear = is_key;
          ent_digit = is_digit;
          ent_dot   = is_dot;
          ent_load  = mem_rc;
        end
        default: ;
      endcase
      if (btn == B_ON) ent_clear = 1'b1;
    end
  end

  calc_entry #(.NumDigits(NumDigits)) u_entry (
    .clk         (clk_i),
    .rst_n       (rst_ni),
    .clear       (ent_clear),
    .digit_valid (ent_digit),
    .digit       (btn_i[3:0]),
    .dot_valid   (ent_dot),
    .load        (ent_load),
    .load_value  (ent_load_val),
    .value       (ent_val)
  );

  assign disp_val = in_entry ? ent_val : disp_q;

  // Which key press launches an ALU transaction, with what operands.
  always_comb begin
    issue   = 1'b0;
    iss_a   = a_q;
    iss_b   = ent_val;
    iss_sub = sub_q;
    iss_op  = pend_op_q;
    iss_ret = S_RESULT;
    iss_mem = 1'b0;
    if (take) begin
      case (state_q)
        S_OP_PEND: if (btn == B_OP_EQ) begin
          issue = 1'b1;
          iss_b = a_q;
        end
        S_ENTRY_B: if (is_op) begin
          issue   = 1'b1;
          iss_ret = S_OP_PEND;
        end else if (btn == B_OP_EQ) begin
          issue = 1'b1;
        end
        default: ;
      endcase
`ifdef CALC_MEMORY_EN
      if (mem_addsub && state_q inside {S_ENTRY_A, S_OP_PEND, S_ENTRY_B, S_RESULT}) begin
        issue   = 1'b1;
        iss_mem = 1'b1;
        iss_a   = mem_q;
        iss_b   = disp_val;
        iss_sub = (btn == B_MEM_SUB);
        iss_op  = OP_ADD;
        iss_ret = in_entry ? S_RESULT : state_q;
      end
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_OFF;
      ret_q     <= S_RESULT;
      a_q       <= NUM_ZERO;
      disp_q    <= NUM_ZERO;
      pend_op_q <= OP_NONE;
      sub_q     <= 1'b0;
      busy_q    <= 1'b0;
      alu_req_q <= 1'b0;
      disp_en_q <= 1'b0;
      alu_op_q  <= OP_NONE;
      alu_a_q   <= NUM_ZERO;
      alu_b_q   <= NUM_ZERO;
`ifdef CALC_MEMORY_EN
      mem_q     <= NUM_ZERO;
      mem_op_q  <= 1'b0;
`endif
    end else if (state_q == S_ALU_WAIT) begin
      if (alu_ack_i) begin
        alu_req_q <= 1'b0;
        busy_q    <= 1'b0;
        if (result.error) begin
          disp_q  <= result;
          state_q <= S_ERROR;
        end
`ifdef CALC_MEMORY_EN
        else if (mem_op_q) begin
          mem_q   <= result;
          state_q <= ret_q;
        end
`endif
        else begin
          a_q     <= result;
          disp_q  <= result;
          state_q <= ret_q;
        end
      end
    end else if (take) begin
      if (btn == B_ON) begin
        state_q   <= S_ENTRY_A;
        a_q       <= NUM_ZERO;
        disp_q    <= NUM_ZERO;
        pend_op_q <= OP_NONE;
        sub_q     <= 1'b0;
        disp_en_q <= 1'b1;
      end else if (btn == B_OFF) begin
        state_q   <= S_OFF;
        disp_en_q <= 1'b0;
      end else if (issue) begin
        alu_a_q   <= iss_a;
        alu_b_q   <= iss_sub ? neg(iss_b) : iss_b;
        alu_op_q  <= iss_op;
        alu_req_q <= 1'b1;
        busy_q    <= 1'b1;
        ret_q     <= iss_ret;
        state_q   <= S_ALU_WAIT;
`ifdef CALC_MEMORY_EN
        mem_op_q  <= iss_mem;
`endif
        // Chained op: the new operator becomes the pending one.
        if (is_op) begin
          pend_op_q <= button2op(btn);
          sub_q     <= (btn == B_OP_SUB);
        end
        // Memory op from an entry state lands in RESULT showing the entry.
        if (iss_mem && in_entry) begin
          a_q    <= ent_val;
          disp_q <= ent_val;
        end
      end else begin
        case (state_q)
          S_ENTRY_A: if (is_op) begin
            a_q       <= ent_val;
            disp_q    <= ent_val;
            pend_op_q <= button2op(btn);
            sub_q     <= (btn == B_OP_SUB);
            state_q   <= S_OP_PEND;
          end
          S_OP_PEND: if (is_op) begin
            pend_op_q <= button2op(btn);
            sub_q     <= (btn == B_OP_SUB);
          end else if (is_key || mem_rc) begin
            state_q <= S_ENTRY_B;
          end
          S_RESULT: if (is_op) begin
            pend_op_q <= button2op(btn);
            sub_q     <= (btn == B_OP_SUB);
            state_q   <= S_OP_PEND;
          end else if (is_key || mem_rc) begin
            state_q <= S_ENTRY_A;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy_o       = busy_q;
  assign alu_req_o    = alu_req_q;
  assign alu_op_o     = alu_op_q;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign display_o    = disp_val;
  assign display_en_o = disp_en_q;

endmodule

// File: tb/tb_calc_sequencer.sv
`timescale 1ns/1ps
module tb_calc_sequencer;
  import calc_pkg::*;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       btn_valid = 1'b0, alu_ack = 1'b0;
  logic [4:0] btn = 5'(B_NONE);
  logic       busy, alu_req, display_en, mem_flag;
  logic [1:0] alu_op;
  num_t       alu_a, alu_b, alu_result, display;

  calc_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n), .btn_valid_i(btn_valid), .btn_i(btn),
    .busy_o(busy), .alu_req_o(alu_req), .alu_op_o(alu_op),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_ack_i(alu_ack),
    .alu_result_i(alu_result), .display_o(display),
    .display_en_o(display_en), .mem_flag_o(mem_flag)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic num_t mk(longint sig, int ex, bit sgn, bit err);
    num_t   n = NUM_ZERO;
    longint s = sig;
    for (int i = 0; i < NumDigits; i++) begin
      n.significand[i] = bcd_t'(s % 10);
      s = s / 10;
    end
    n.exponent = ExpW'(ex);
    n.sign     = sgn;
    n.error    = err;
    return n;
  endfunction

  // ALU stand-in: acks in request cycle lat+1, records the first-cycle operands.
  bit   auto_alu = 1'b1;
  int   lat = 0, age = 0, req_seen = 0, req_cycles = 0;
  num_t res_next = NUM_ZERO, cap_a, cap_b;
  logic [1:0] cap_op;

  initial begin
    alu_result = NUM_ZERO;
    forever begin
      @(negedge clk);
      if (!auto_alu) age = 0;
      else if (alu_ack) begin
        alu_ack = 1'b0;
        age = 0;
      end else if (alu_req) begin
        if (age == 0) begin
          req_seen++;
          cap_a = alu_a; cap_b = alu_b; cap_op = alu_op;
        end
        req_cycles++;
        if (age >= lat) begin
          alu_ack = 1'b1;
          alu_result = res_next;
        end else age++;
      end
    end
  end

  task automatic press(active_button_t b);
    @(negedge clk);
    btn_valid = 1'b1;
    btn = 5'(b);
    @(negedge clk);
    btn_valid = 1'b0;
    btn = 5'(B_NONE);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("busy_timeout", 64'(busy), 64'd0);
  endtask

  // ---------------- reference model (calculator semantics) ----------------
  localparam int MOFF = 0, MA = 1, MPEND = 2, MB = 3, MRES = 4, MERR = 5;
  int     m_mode = MOFF, m_cnt = 0, m_exp = 0;
  bit     m_dot = 0, m_sub = 0, issued = 0;
  longint m_sig = 0;
  num_t   m_a = NUM_ZERO, m_disp = NUM_ZERO, e_a, e_b;
  op_t    m_op = OP_NONE, e_op;

  function automatic num_t m_entry();
    return mk(m_sig, m_exp, 1'b0, 1'b0);
  endfunction

  task automatic m_clear();
    m_sig = 0; m_cnt = 0; m_exp = 0; m_dot = 0;
  endtask

  task automatic m_key(active_button_t b);
    int d;
    if (b == B_DOT) m_dot = 1;
    else begin
      d = int'(b);
      if (!(m_sig == 0 && !m_dot && d == 0) && m_cnt < NumDigits) begin
        m_sig = m_sig * 10 + d;
        m_cnt++;
        if (m_dot) m_exp++;
      end
    end
  endtask

  task automatic m_setop(active_button_t b);
    m_op  = (b == B_OP_MUL) ? OP_MUL : (b == B_OP_DIV) ? OP_DIV : OP_ADD;
    m_sub = (b == B_OP_SUB);
  endtask

  task automatic m_issue(num_t b, int ret);
    issued = 1;
    e_a = m_a;
    e_b = b;
    if (m_sub) e_b.sign = ~e_b.sign;
    e_op = m_op;
    m_disp = res_next;
    if (res_next.error) m_mode = MERR;
    else begin
      m_a = res_next;
      m_mode = ret;
    end
  endtask

  task automatic m_press(active_button_t b);
    bit key, op;
    key = (b <= B_9) || (b == B_DOT);
    op  = b inside {B_OP_ADD, B_OP_SUB, B_OP_MUL, B_OP_DIV};
    issued = 0;
    if (b == B_ON) begin
      m_mode = MA; m_clear(); m_a = NUM_ZERO; m_disp = NUM_ZERO; m_op = OP_NONE; m_sub = 0;
    end else if (b == B_OFF) m_mode = MOFF;
    else case (m_mode)
      MA:    if (key) m_key(b);
             else if (op) begin m_a = m_entry(); m_disp = m_a; m_setop(b); m_mode = MPEND; end
      MB:    if (key) m_key(b);
             else if (op) begin m_issue(m_entry(), MPEND); m_setop(b); end
             else if (b == B_OP_EQ) m_issue(m_entry(), MRES);
      MPEND: if (op) m_setop(b);
             else if (key) begin m_clear(); m_key(b); m_mode = MB; end
             else if (b == B_OP_EQ) m_issue(m_a, MRES);
      MRES:  if (key) begin m_clear(); m_key(b); m_mode = MA; end
             else if (op) begin m_setop(b); m_mode = MPEND; end
      default: ;
    endcase
  endtask

  function automatic active_button_t pick();
    int r = int'($urandom_range(0, 99));
    if (r < 45) return active_button_t'(5'($urandom_range(0, 9)));
    if (r < 52) return B_DOT;
    if (r < 60) return B_OP_ADD;
    if (r < 65) return B_OP_SUB;
    if (r < 70) return B_OP_MUL;
    if (r < 74) return B_OP_DIV;
    if (r < 86) return B_OP_EQ;
    if (r < 90) return B_ON;
    if (r < 92) return B_OFF;
    if (r < 94) return B_OP_PERCENT;
    if (r < 96) return B_OP_SQRT;
    if (r < 98) return B_NONE;
    return B_UNKNOWN;
  endfunction

  typedef struct packed {
    active_button_t b;
    logic [31:0]    sig;
    logic [3:0]     ex;
    logic           en;
  } vec_t;

  initial begin
    vec_t tbl[$];
    int   prev;
    num_t errv;

    // Reset state
    #12;
    chk("rst_display_en", 64'(display_en), 64'd0);
    chk("rst_alu_req", 64'(alu_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_flag", 64'(mem_flag), 64'd0);
    chk("rst_display", 64'(display), 64'(NUM_ZERO));
    chk("rst_alu_a", 64'(alu_a), 64'(NUM_ZERO));
    chk("rst_alu_b", 64'(alu_b), 64'(NUM_ZERO));
    chk("rst_alu_op", 64'(alu_op), 64'(OP_NONE));
    @(negedge clk);
    rst_n = 1'b1;

    // Digit entry vectors: dot/exponent, digit-count cap, leading zeros
    tbl.push_back(vec_t'{B_ON, 32'd0, 4'd0, 1'b1});
    tbl.push_back(vec_t'{B_1, 32'd1, 4'd0, 1'b1});
    tbl.push_back(vec_t'{B_2, 32'd12, 4'd0, 1'b1});
    tbl.push_back(vec_t'{B_DOT, 32'd12, 4'd0, 1'b1});
    tbl.push_back(vec_t'{B_5, 32'd125, 4'd1, 1'b1});
    tbl.push_back(vec_t'{B_DOT, 32'd125, 4'd1, 1'b1});
    tbl.push_back(vec_t'{B_ON, 32'd0, 4'd0, 1'b1});
    tbl.push_back(vec_t'{B_1, 32'd1, 4'd0, 1'b1});
    tbl.push_back(vec_t'{B_2, 32'd12, 4'd0, 1'b1});
    tbl.push_back(vec_t'{B_3, 32'd123, 4'd0, 1'b1});
    tbl.push_back(vec_t'{B_4, 32'd1234, 4'd0, 1'b1});
    tbl.push_back(vec_t'{B_5, 32'd12345, 4'd0, 1'b1});
    tbl.push_back(vec_t'{B_6, 32'd123456, 4'd0, 1'b1});
    tbl.push_back(vec_t'{B_7, 32'd1234567, 4'd0, 1'b1});
    tbl.push_back(vec_t'{B_8, 32'd12345678, 4'd0, 1'b1});
    tbl.push_back(vec_t'{B_9, 32'd12345678, 4'd0, 1'b1});
    tbl.push_back(vec_t'{B_ON, 32'd0, 4'd0, 1'b1});
    tbl.push_back(vec_t'{B_0, 32'd0, 4'd0, 1'b1});
    tbl.push_back(vec_t'{B_0, 32'd0, 4'd0, 1'b1});
    tbl.push_back(vec_t'{B_3, 32'd3, 4'd0, 1'b1});
    tbl.push_back(vec_t'{B_OP_SQRT, 32'd3, 4'd0, 1'b1});
    tbl.push_back(vec_t'{B_DOT, 32'd3, 4'd0, 1'b1});
    tbl.push_back(vec_t'{B_0, 32'd30, 4'd1, 1'b1});
    tbl.push_back(vec_t'{B_OFF, 32'd0, 4'd0, 1'b0});
    tbl.push_back(vec_t'{B_7, 32'd0, 4'd0, 1'b0});
    tbl.push_back(vec_t'{B_ON, 32'd0, 4'd0, 1'b1});
    foreach (tbl[i]) begin
      press(tbl[i].b);
      chk($sformatf("vec%0d_display", i), 64'(display), 64'(mk(longint'(tbl[i].sig), int'(tbl[i].ex), 1'b0, 1'b0)));
      chk($sformatf("vec%0d_en", i), 64'(display_en), 64'(tbl[i].en));
    end

    // 7 + 5 = with a slow ALU, buttons dropped while busy
    press(B_ON); press(B_7); press(B_OP_ADD); press(B_5);
    lat = 2; res_next = mk(12, 0, 0, 0); req_cycles = 0; prev = req_seen;
    press(B_OP_EQ);
    chk("add_busy", 64'(busy), 64'd1);
    chk("add_req", 64'(alu_req), 64'd1);
    press(B_3);
    wait_idle();
    chk("add_req_cycles", 64'(req_cycles), 64'd3);
    chk("add_req_count", 64'(req_seen), 64'(prev + 1));
    chk("add_op", 64'(cap_op), 64'(OP_ADD));
    chk("add_a", 64'(cap_a), 64'(mk(7, 0, 0, 0)));
    chk("add_b", 64'(cap_b), 64'(mk(5, 0, 0, 0)));
    chk("add_display", 64'(display), 64'(mk(12, 0, 0, 0)));
    chk("add_req_low", 64'(alu_req), 64'd0);

    // 9 - 4 * 2 = : chain
    press(B_ON); press(B_9); press(B_OP_SUB); press(B_4);
    lat = 0; res_next = mk(5, 0, 0, 0);
    press(B_OP_MUL); wait_idle();
    chk("sub_op", 64'(cap_op), 64'(OP_ADD));
    chk("sub_a", 64'(cap_a), 64'(mk(9, 0, 0, 0)));
    chk("sub_b", 64'(cap_b), 64'(mk(4, 0, 1, 0)));
    chk("sub_display", 64'(display), 64'(mk(5, 0, 0, 0)));
    press(B_2);
    res_next = mk(10, 0, 0, 0);
    press(B_OP_EQ); wait_idle();
    chk("mul_op", 64'(cap_op), 64'(OP_MUL));
    chk("mul_a", 64'(cap_a), 64'(mk(5, 0, 0, 0)));
    chk("mul_b", 64'(cap_b), 64'(mk(2, 0, 0, 0)));
    chk("mul_display", 64'(display), 64'(mk(10, 0, 0, 0)));

    // 1 / 0 = -> error, sticky until ON
    press(B_ON); press(B_1); press(B_OP_DIV); press(B_0);
    errv = mk(0, 0, 0, 1); res_next = errv; lat = 1;
    press(B_OP_EQ); wait_idle();
    chk("div_op", 64'(cap_op), 64'(OP_DIV));
    chk("div_b", 64'(cap_b), 64'(NUM_ZERO));
    chk("err_display", 64'(display), 64'(errv));
    press(B_7); press(B_OP_ADD);
    chk("err_sticky", 64'(display), 64'(errv));
    press(B_ON);
    chk("err_clear", 64'(display), 64'(NUM_ZERO));
    press(B_4);
    chk("err_entry", 64'(display), 64'(mk(4, 0, 0, 0)));

    // Async reset mid-wait, then a stray ack
    auto_alu = 1'b0;
    press(B_ON); press(B_1); press(B_OP_ADD); press(B_2); press(B_OP_EQ);
    chk("hold_req", 64'(alu_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", 64'(alu_req), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    alu_result = mk(77, 0, 0, 0);
    alu_ack = 1'b1;
    @(negedge clk);
    alu_ack = 1'b0;
    chk("stray_display", 64'(display), 64'(NUM_ZERO));
    chk("stray_en", 64'(display_en), 64'd0);
    chk("stray_req", 64'(alu_req), 64'd0);
    auto_alu = 1'b1;

    // Memory keys
    press(B_ON); press(B_6);
    res_next = mk(6, 0, 0, 0); lat = 1; prev = req_seen;
    press(B_MEM_ADD); wait_idle();
`ifdef CALC_MEMORY_EN
    chk("mem_req_count", 64'(req_seen), 64'(prev + 1));
    chk("mem_a", 64'(cap_a), 64'(NUM_ZERO));
    chk("mem_b", 64'(cap_b), 64'(mk(6, 0, 0, 0)));
    chk("mem_op", 64'(cap_op), 64'(OP_ADD));
    chk("mem_flag", 64'(mem_flag), 64'd1);
    press(B_ON);
    chk("mem_on_display", 64'(display), 64'(NUM_ZERO));
    chk("mem_on_flag", 64'(mem_flag), 64'd1);
    press(B_MEM_RC);
    chk("mem_rc_display", 64'(display), 64'(mk(6, 0, 0, 0)));
`else
    chk("nomem_req_count", 64'(req_seen), 64'(prev));
    chk("nomem_display", 64'(display), 64'(mk(6, 0, 0, 0)));
    press(B_ON); press(B_MEM_RC);
    chk("nomem_rc_display", 64'(display), 64'(NUM_ZERO));
    chk("nomem_flag", 64'(mem_flag), 64'd0);
`endif

    // Randomized key streams against the model
    lat = 0;
    press(B_ON); m_press(B_ON);
    for (int i = 0; i < 400; i++) begin
      active_button_t b;
      b = pick();
      lat = int'($urandom_range(0, 3));
      res_next = mk(longint'($urandom_range(0, 99999999)), int'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
      prev = req_seen;
      m_press(b);
      press(b);
      wait_idle();
      chk($sformatf("rnd%0d_display", i), 64'(display),
          64'(((m_mode == MA) || (m_mode == MB)) ? m_entry() : m_disp));
      chk($sformatf("rnd%0d_en", i), 64'(display_en), 64'(m_mode != MOFF));
      if (issued) begin
        chk($sformatf("rnd%0d_req", i), 64'(req_seen), 64'(prev + 1));
        chk($sformatf("rnd%0d_a", i), 64'(cap_a), 64'(e_a));
        chk($sformatf("rnd%0d_b", i), 64'(cap_b), 64'(e_b));
        chk($sformatf("rnd%0d_op", i), 64'(cap_op), 64'(e_op));
      end else begin
        chk($sformatf("rnd%0d_noreq", i), 64'(req_seen), 64'(prev));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
